// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Tag covers everything above offset and index, excluding byte bits [1:0].
    function automatic int tag_bits(input int lines, input int words);
        return 30 - $clog2(lines) - $clog2(words);
    endfunction

endpackage

// File: rtl/icache_responder_if.sv
// Line-refill bus between the instruction cache (master) and the memory arbiter (slave).
interface icache_responder_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the cache: combinational lookup port, one word write
// port for refill beats, tag/valid update on the last beat, and bulk invalidate.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int WORDS = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [idx_bits(LINES)-1:0]          i_rd_idx,
    input  logic [off_bits(WORDS)-1:0]          i_rd_off,
    output logic                                o_rd_valid,
    output logic [tag_bits(LINES, WORDS)-1:0]   o_rd_tag,
    output logic [31:0]                         o_rd_data,
    input  logic                                i_wr_en,
    input  logic [idx_bits(LINES)-1:0]          i_wr_idx,
    input  logic [off_bits(WORDS)-1:0]          i_wr_off,
    input  logic [31:0]                         i_wr_data,
    input  logic                                i_tag_we,
    input  logic [tag_bits(LINES, WORDS)-1:0]   i_wr_tag,
    input  logic                                i_set_valid,
    input  logic                                i_inval
);
    localparam int TAG_W = tag_bits(LINES, WORDS);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [31:0]       r_data [LINES*WORDS];

    // Invalidate wins over a same-cycle valid set so a fence.i on the last beat sticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (i_inval) begin
            r_valid <= '0;
        end else if (i_set_valid) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
        end
        if (i_tag_we) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[{i_rd_idx, i_rd_off}];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: zero-latency hit path from the fetch PC
// and a single-outstanding line refill (IDLE -> REQ -> FILL) toward memory.
module icache_responder
    import icache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         addr,
    output logic [31:0]         inst0,
    output logic                hit,
    output logic                stall,
    input  logic                inval,
    icache_responder_if.master  mem
);
    localparam int OFF_W  = off_bits(WORDS);
    localparam int IDX_W  = idx_bits(LINES);
    localparam int TAG_W  = tag_bits(LINES, WORDS);
    localparam int LO     = OFF_W + 2;
    localparam int TAG_LO = IDX_W + OFF_W + 2;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

    state_t            r_state;
    logic [OFF_W-1:0]  r_cnt;
    logic              r_cancel;
    logic              r_req_valid;
    logic [31:LO]      r_line_base;

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [31:0]       w_rd_data;
    logic              w_hit;
    logic              w_beat;
    logic              w_last;
    logic              w_set_valid;
    logic              w_unused_addr;

    assign w_off         = addr[LO-1:2];
    assign w_idx         = addr[TAG_LO-1:LO];
    assign w_tag         = addr[31:TAG_LO];
    assign w_unused_addr = ^addr[1:0];

    icache_line_store #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .i_rd_idx    (w_idx),
        .i_rd_off    (w_off),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_data   (w_rd_data),
        .i_wr_en     (w_beat),
        .i_wr_idx    (r_line_base[TAG_LO-1:LO]),
        .i_wr_off    (r_cnt),
        .i_wr_data   (mem.mem_rdata),
        .i_tag_we    (w_last),
        .i_wr_tag    (r_line_base[31:TAG_LO]),
        .i_set_valid (w_set_valid),
        .i_inval     (inval)
    );

    // Lookup only counts in IDLE so a half-written line can never be served.
    assign w_hit       = w_rd_valid && (w_rd_tag == w_tag) && (r_state == IDLE);
    assign w_beat      = (r_state == FILL) && mem.mem_rvalid;
    assign w_last      = w_beat && (r_cnt == LAST_BEAT);
    assign w_set_valid = w_last && !r_cancel && !inval;

    assign hit   = w_hit;
    assign stall = reset & ~w_hit;
    assign inst0 = w_hit ? w_rd_data : NOP_INSN;

    assign mem.mem_req_valid = r_req_valid;
    assign mem.mem_req_addr  = {r_line_base, {LO{1'b0}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cancel    <= 1'b0;
            r_req_valid <= 1'b0;
            r_line_base <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cancel <= 1'b0;
                    if (!inval && !w_hit) begin
                        r_line_base <= addr[31:LO];
                        r_req_valid <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    if (inval) r_cancel <= 1'b1;
                    if (mem.mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= FILL;
                    end
                end
                FILL: begin
                    if (inval) r_cancel <= 1'b1;
                    if (mem.mem_rvalid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_BEAT) begin
                            r_cancel <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/icache_responder.md
# icache_responder

Responder side of the fetch-to-instruction-memory interface: accepts the PC presented by the fetch stage, returns the 32-bit instruction at that address, and raises `stall` while a miss is serviced. Direct-mapped, read-only instruction cache with a single-outstanding line-refill state machine toward the memory bus. Sits between the fetch stage and the memory arbiter; `stall` feeds the pipeline stall network that freezes the PC register.

## Interface
- `LINES`, 64: number of cache lines (power of two, ≥2).
- `WORDS`, 4: 32-bit words per line (power of two, ≥2).
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous active-low reset (asserted at 0, released synchronously to `clk` by the reset tree).
- `addr`  in  32  fetch PC; bits [1:0] ignored.
- `inst0`  out  32  instruction at `addr` when `hit`=1, else NOP 32'h00000013.
- `hit`  out  1  `inst0` is valid this cycle.
- `stall`  out  1  fetch must hold `addr`; equals !`hit` outside reset.
- `inval`  in  1  single-cycle pulse: invalidate entire cache (fence.i).
- `mem_req_valid`  out  1  line-read request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_req_addr`  out  32  line-aligned byte address (offset bits zero).
- `mem_rvalid`  in  1  read-data beat valid.
- `mem_rdata`  in  32  read-data beat.

## Operation
- Address split: offset = addr[log2(WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits.
- Lookup is combinational from stored valid/tag/data: `hit` = valid[index] && tag match && state==IDLE.
- FSM states: IDLE, REQ, FILL.
  - IDLE: on miss (and `inval`=0), latch line address of `addr`, go REQ. Hit: stay.
  - REQ: `mem_req_valid`=1, `mem_req_addr`=latched line address; on `mem_req_ready`=1 go FILL, beat counter=0.
  - FILL: each `mem_rvalid`=1 writes `mem_rdata` to word[counter] of latched index, counter+1. Beats arrive in order word 0..WORDS-1. On last beat: write tag, set valid (unless cancelled), go IDLE.
- `mem_rvalid` in IDLE or REQ: ignored.
- `addr` changes during REQ/FILL: refill completes for latched line; lookup resumes on current `addr` in IDLE (may miss again).
- `inval` in IDLE: all valid bits cleared next edge; no miss started that cycle. `inval` in REQ/FILL: all valid bits cleared; running refill completes its bus transaction but does not set valid (cancel flag, cleared on entry to IDLE).
- `inval` coinciding with last FILL beat: line ends invalid.
- No writes from fetch side; no self-modifying-code coherence beyond `inval`.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE, all valid bits 0, cancel flag 0, counter 0, `mem_req_valid`=0, `hit`=0, `stall`=0, `inst0`=NOP. Tag/data arrays not reset.
- Reset mid-refill: FSM returns to IDLE immediately; partially filled line stays invalid; outstanding memory beats after release are ignored (memory side is reset by same tree).
- Hit latency: 0 cycles (`inst0`/`hit` combinational from `addr`).
- Miss penalty with `mem_req_ready` immediately high and one beat per cycle starting the cycle after request acceptance: stall high for WORDS+2 cycles (IDLE detect, REQ, WORDS FILL cycles); hit in the cycle after last beat.
- `mem_req_valid` once raised stays high with stable `mem_req_addr` until accepted.
- Counter width log2(WORDS), wraps to 0 after last beat.

## Structure
- Package `icache_pkg`: FSM state enum (IDLE, REQ, FILL), NOP constant 32'h00000013, field-width helper functions for offset/index/tag.
- Sub-module `icache_line_store`: valid bit vector (async-reset), tag array, data array; one combinational read port, one word write port, tag/valid write, bulk invalidate.
- Top `icache_responder`: address split, FSM, beat counter, cancel flag, bus outputs.

## Test plan
- Cold miss: reset, `addr`=0x100, ready=1, beats 0xA0..0xA3 -> `mem_req_addr`=0x100, stall high 6 cycles, then `inst0`=0xA0, `hit`=1; `addr`=0x10C hits with 0xA3 same cycle.
- Conflict: after fill of 0x100, `addr`=0x100+LINES*16 (0x500) -> miss, refill replaces line; returning to 0x100 misses again.
- Backpressure: `mem_req_ready` low 5 cycles -> `mem_req_valid` and `mem_req_addr` stable throughout; gaps in `mem_rvalid` extend FILL without corrupting word order.
- Inval during FILL at beat 2 -> bus transaction completes, next lookup of same address misses and refetches; `inval` in IDLE after fills -> all previously hitting addresses miss.
- Address change mid-refill: miss on 0x100, switch `addr` to 0x200 during FILL -> 0x100 line fills, then new miss on 0x200 requests 0x200.
- Reset asserted during FILL beat 1 -> outputs immediately at reset values; after release `addr`=0x100 misses and issues a fresh request.
